// File: rtl/level_ram_fwd_pkg.sv
// pheapTypes: shared heap entry type, empty marker, clear FSM states and address-width helper.
package pheapTypes;
    typedef logic [7:0] entry_t;
    localparam entry_t ENTRY_EMPTY = '1;
    typedef enum logic {CLEAR, READY} clr_state_t;
    function automatic int level_aw(input int level);
        return (level > 1) ? level - 1 : 1;
    endfunction
endpackage

// File: rtl/level_ram_fwd_if.sv
// level_ram_fwd_if: user-side clear and dual-port access bundle for one heap level.
interface level_ram_fwd_if import pheapTypes::*; #(
    parameter int LEVEL = 2,
    parameter int WIDTH = $bits(entry_t)
);
    localparam int AW = level_aw(LEVEL);
    logic             clear_req, busy, coll;
    logic             en_a, we_a, qv_a, en_b, we_b, qv_b;
    logic [AW-1:0]    addr_a, addr_b;
    logic [WIDTH-1:0] data_a, q_a, data_b, q_b;
    modport master (
        output clear_req, en_a, we_a, addr_a, data_a, en_b, we_b, addr_b, data_b,
        input  busy, coll, q_a, qv_a, q_b, qv_b
    );
    modport slave (
        input  clear_req, en_a, we_a, addr_a, data_a, en_b, we_b, addr_b, data_b,
        output busy, coll, q_a, qv_a, q_b, qv_b
    );
endinterface

// File: rtl/level_ram_fwd_core.sv
// ram_tdp_core: unreset true dual-port array, write-first per port; port A wins a same-address double write.
module ram_tdp_core #(
    parameter int DEPTH = 2,
    parameter int AW    = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             en_a,
    input  logic             we_a,
    input  logic [AW-1:0]    addr_a,
    input  logic [WIDTH-1:0] din_a,
    output logic [WIDTH-1:0] dout_a,
    input  logic             en_b,
    input  logic             we_b,
    input  logic [AW-1:0]    addr_b,
    input  logic [WIDTH-1:0] din_b,
    output logic [WIDTH-1:0] dout_b
);
    logic [WIDTH-1:0] mem [DEPTH];
    // we_x writes regardless of en_x so the clear sequencer can fill without disturbing dout
    always_ff @(posedge clk) begin
        if (we_b) mem[addr_b] <= din_b;
        if (we_a) mem[addr_a] <= din_a;
        if (en_a) dout_a <= we_a ? din_a : mem[addr_a];
        if (en_b) dout_b <= we_b ? din_b : mem[addr_b];
    end
endmodule

// File: rtl/level_ram_fwd.sv
// level_ram_fwd: one heap level with clear sequencer, write-through, cross-port forwarding,
// collision flag and optional output register.
module level_ram_fwd import pheapTypes::*; #(
    parameter int               LEVEL     = 2,
    parameter int               WIDTH     = $bits(entry_t),
    parameter bit               OUT_REG   = 1'b0,
    parameter logic [WIDTH-1:0] EMPTY_VAL = WIDTH'(ENTRY_EMPTY)
) (
    input  logic            clk,
    input  logic            rst_n,
    level_ram_fwd_if.slave  bus
);
    localparam int AW    = level_aw(LEVEL);
    localparam int DEPTH = 2 ** (LEVEL - 1);
    clr_state_t       state, nstate;
    logic [AW-1:0]    cnt, ncnt, ea, eb;
    logic             busy, ua, ub, uwa, uwb, same, fa, fb;
    logic             za, zb, sfa, sfb, qv1_a, qv1_b, qv2_a, qv2_b, coll_r;
    logic [WIDTH-1:0] fq_a, fq_b, core_a, core_b, q1_a, q1_b, q2_a, q2_b;

    assign busy = state == CLEAR;
    assign ea   = (LEVEL > 1) ? bus.addr_a : '0;
    assign eb   = (LEVEL > 1) ? bus.addr_b : '0;
    assign ua   = bus.en_a & ~busy;
    assign ub   = bus.en_b & ~busy;
    assign uwa  = ua & bus.we_a;
    assign uwb  = ub & bus.we_b;
    assign same = ea == eb;
    // A only needs B's data when A reads; B takes A's data whenever A writes (A wins a double write)
    assign fa   = ua & ~bus.we_a & uwb & same;
    assign fb   = ub & uwa & same;

    ram_tdp_core #(.DEPTH(DEPTH), .AW(AW), .WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .en_a   (ua),
        .we_a   (busy | uwa),
        .addr_a (busy ? cnt : ea),
        .din_a  (busy ? EMPTY_VAL : bus.data_a),
        .dout_a (core_a),
        .en_b   (ub),
        .we_b   (uwb),
        .addr_b (eb),
        .din_b  (bus.data_b),
        .dout_b (core_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= nstate;
            cnt   <= ncnt;
        end
    end

    always_comb begin
        nstate = state;
        ncnt   = cnt;
        if (state == CLEAR) begin
            ncnt   = cnt + 1'b1;
            nstate = (cnt == AW'(DEPTH - 1)) ? READY : CLEAR;
        end else if (bus.clear_req) begin
            ncnt   = '0;
            nstate = CLEAR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            za     <= 1'b1;
            zb     <= 1'b1;
            sfa    <= 1'b0;
            sfb    <= 1'b0;
            fq_a   <= '0;
            fq_b   <= '0;
            qv1_a  <= 1'b0;
            qv1_b  <= 1'b0;
            coll_r <= 1'b0;
            q2_a   <= '0;
            q2_b   <= '0;
            qv2_a  <= 1'b0;
            qv2_b  <= 1'b0;
        end else begin
            qv1_a  <= ua;
            qv1_b  <= ub;
            coll_r <= uwa & uwb & same;
            if (ua) begin
                za  <= 1'b0;
                sfa <= fa;
            end
            if (ub) begin
                zb  <= 1'b0;
                sfb <= fb;
            end
            if (fa) fq_a <= bus.data_b;
            if (fb) fq_b <= bus.data_a;
            q2_a   <= q1_a;
            q2_b   <= q1_b;
            qv2_a  <= qv1_a;
            qv2_b  <= qv1_b;
        end
    end

    // za/zb stand in for the unreset core output until the first access after reset
    assign q1_a     = za ? '0 : sfa ? fq_a : core_a;
    assign q1_b     = zb ? '0 : sfb ? fq_b : core_b;
    assign bus.q_a  = OUT_REG ? q2_a : q1_a;
    assign bus.q_b  = OUT_REG ? q2_b : q1_b;
    assign bus.qv_a = OUT_REG ? qv2_a : qv1_a;
    assign bus.qv_b = OUT_REG ? qv2_b : qv1_b;
    assign bus.busy = busy;
    assign bus.coll = coll_r;
endmodule

// File: tb/tb_level_ram_fwd.sv
// tb_level_ram_fwd: directed checks of a LEVEL=3 latency-1 instance and a LEVEL=1 latency-2 instance.
module tb_level_ram_fwd;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n;

    level_ram_fwd_if #(.LEVEL(3), .WIDTH(8)) f3 ();
    level_ram_fwd_if #(.LEVEL(1), .WIDTH(8)) f1 ();

    level_ram_fwd #(.LEVEL(3), .WIDTH(8), .OUT_REG(1'b0), .EMPTY_VAL(8'hFF)) d3 (
        .clk(clk), .rst_n(rst_n), .bus(f3));
    level_ram_fwd #(.LEVEL(1), .WIDTH(8), .OUT_REG(1'b1), .EMPTY_VAL(8'h5A)) d1 (
        .clk(clk), .rst_n(rst_n), .bus(f1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pa(input logic en, input logic we, input logic [1:0] a, input logic [7:0] d);
        f3.en_a = en; f3.we_a = we; f3.addr_a = a; f3.data_a = d;
    endtask

    task automatic pb(input logic en, input logic we, input logic [1:0] a, input logic [7:0] d);
        f3.en_b = en; f3.we_b = we; f3.addr_b = a; f3.data_b = d;
    endtask

    task automatic wait_ready(input string tag, input int exp_cycles, input int start);
        n = start;
        while (f3.busy && n < 20) begin
            tick();
            n++;
        end
        chk(tag, n, exp_cycles);
    endtask

    task automatic read_all(input string tag, input logic [7:0] exp);
        for (int i = 0; i < 4; i++) begin
            pa(1, 0, 2'(i), 0);
            tick();
            chk({tag, "_qv"}, f3.qv_a, 1);
            chk({tag, "_q"}, f3.q_a, exp);
        end
        pa(0, 0, 0, 0);
    endtask

    initial begin
        f3.clear_req = 0; pa(0, 0, 0, 0); pb(0, 0, 0, 0);
        f1.clear_req = 0; f1.en_a = 0; f1.we_a = 0; f1.addr_a = 0; f1.data_a = 0;
        f1.en_b = 0; f1.we_b = 0; f1.addr_b = 0; f1.data_b = 0;
        tick();
        tick();
        chk("rst_busy", f3.busy, 1);
        chk("rst_q_a", f3.q_a, 0);
        chk("rst_qv_b", f3.qv_b, 0);
        chk("rst_coll", f3.coll, 0);
        chk("rst_l1_q", f1.q_a, 0);
        rst_n = 1;
        chk("busy_rel", f3.busy, 1);
        wait_ready("clr_len", 4, 0);
        read_all("init", 8'hFF);
        tick();
        chk("idle_qv", f3.qv_a, 0);
        chk("idle_hold", f3.q_a, 8'hFF);

        pa(1, 1, 2, 8'h15);
        tick();
        chk("wt_q", f3.q_a, 8'h15);
        chk("wt_qv", f3.qv_a, 1);
        pa(0, 0, 0, 0); pb(1, 0, 2, 0);
        tick();
        chk("rdb_q", f3.q_b, 8'h15);
        chk("rdb_qv", f3.qv_b, 1);
        chk("rdb_qva", f3.qv_a, 0);

        pa(1, 0, 1, 0); pb(1, 1, 1, 8'h2A);
        tick();
        chk("fwd_qa", f3.q_a, 8'h2A);
        chk("fwd_qb", f3.q_b, 8'h2A);
        chk("fwd_coll", f3.coll, 0);
        pb(0, 0, 0, 0);
        tick();
        chk("fwd_rd", f3.q_a, 8'h2A);

        pa(1, 1, 3, 8'h11); pb(1, 1, 3, 8'h22);
        tick();
        chk("dw_coll", f3.coll, 1);
        chk("dw_qa", f3.q_a, 8'h11);
        chk("dw_qb", f3.q_b, 8'h11);
        pa(1, 0, 3, 0); pb(1, 0, 3, 0);
        tick();
        chk("dw_coll_end", f3.coll, 0);
        chk("dw_rda", f3.q_a, 8'h11);
        chk("dw_rdb", f3.q_b, 8'h11);
        pa(1, 1, 0, 8'h33); pb(1, 1, 1, 8'h44);
        tick();
        chk("dd_coll", f3.coll, 0);
        pa(1, 0, 0, 0); pb(1, 0, 1, 0);
        tick();
        chk("dd_rda", f3.q_a, 8'h33);
        chk("dd_rdb", f3.q_b, 8'h44);

        f3.clear_req = 1; pa(1, 0, 0, 0); pb(0, 0, 0, 0);
        tick();
        f3.clear_req = 0;
        chk("clr_acc_q", f3.q_a, 8'h33);
        chk("clr_acc_qv", f3.qv_a, 1);
        chk("clr_busy", f3.busy, 1);
        pa(1, 1, 2, 8'h99); pb(1, 0, 1, 0);
        tick();
        chk("busy_qva", f3.qv_a, 0);
        chk("busy_qvb", f3.qv_b, 0);
        chk("busy_hold", f3.q_a, 8'h33);
        pa(0, 0, 0, 0); pb(0, 0, 0, 0);
        wait_ready("clr2_len", 4, 1);
        read_all("clr2", 8'hFF);

        for (int i = 0; i < 4; i++) begin
            pa(1, 1, 2'(i), 8'(8'h10 + i));
            tick();
        end
        pa(0, 0, 0, 0);
        f3.clear_req = 1;
        tick();
        f3.clear_req = 0;
        tick();
        tick();
        rst_n = 0;
        #1;
        chk("mid_rst_q", f3.q_a, 0);
        chk("mid_rst_busy", f3.busy, 1);
        tick();
        rst_n = 1;
        wait_ready("restart_len", 4, 0);
        read_all("restart", 8'hFF);

        tick();
        chk("l1_empty_wait", f1.busy, 0);
        f1.en_a = 1; f1.we_a = 0; f1.addr_a = 1;
        tick();
        f1.en_a = 0;
        chk("l1_lat1_qv", f1.qv_a, 0);
        tick();
        chk("l1_empty_qv", f1.qv_a, 1);
        chk("l1_empty_q", f1.q_a, 8'h5A);
        f1.en_a = 1; f1.we_a = 1; f1.addr_a = 0; f1.data_a = 8'h07;
        tick();
        f1.en_a = 0; f1.we_a = 0;
        chk("l1_wr_qv1", f1.qv_a, 0);
        tick();
        chk("l1_wr_qv2", f1.qv_a, 1);
        chk("l1_wr_q", f1.q_a, 8'h07);
        f1.en_a = 1; f1.addr_a = 1;
        tick();
        f1.en_a = 0;
        tick();
        chk("l1_alias_qv", f1.qv_a, 1);
        chk("l1_alias_q", f1.q_a, 8'h07);
        f1.en_b = 1; f1.we_b = 1; f1.addr_b = 1; f1.data_b = 8'h09;
        tick();
        f1.en_b = 0; f1.we_b = 0;
        f1.en_a = 1; f1.addr_a = 0;
        tick();
        f1.en_a = 0;
        tick();
        chk("l1_alias_wr", f1.q_a, 8'h09);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
